// File: rtl/obi_timeout_bridge.sv
// OBI single-outstanding bridge with a response timeout.
// Forwards one upstream OBI transaction at a time to a downstream peripheral
// and synthesises an error response if the peripheral does not answer within
// TIMEOUT cycles of the downstream request being raised.
//
// Handshake summary: upstream s_req is accepted on a rising edge where
// s_req=1 and s_gnt=1 (s_gnt is high only in IDLE outside reset); downstream
// p_req is held with a stable payload until the rising edge where p_gnt=1;
// p_rvalid is a single-cycle pulse honoured only while waiting for it; s_rvalid
// is a single-cycle pulse carrying s_rdata/s_err, which hold afterwards.
module obi_timeout_bridge #(
  parameter int          ADDR_W   = 24,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  output logic              s_gnt,
  input  logic              s_we,
  input  logic [3:0]        s_be,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_rvalid,
  output logic [31:0]       s_rdata,
  output logic              s_err,
  output logic              p_req,
  output logic              p_we,
  output logic [3:0]        p_be,
  output logic [ADDR_W-1:0] p_addr,
  output logic [31:0]       p_wdata,
  input  logic              p_gnt,
  input  logic              p_rvalid,
  input  logic [31:0]       p_rdata,
  output logic [7:0]        timeout_cnt,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Last wait-counter value before the bridge gives up on the peripheral.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic [7:0]          r_wait_cnt;
  logic [7:0]          r_tcnt;
  logic                r_p_req;
  logic                r_p_we;
  logic [3:0]          r_p_be;
  logic [ADDR_W-1:0]   r_p_addr;
  logic [31:0]         r_p_wdata;
  logic                r_s_rvalid;
  logic [31:0]         r_s_rdata;
  logic                r_s_err;
  logic                w_timeout;

  assign w_timeout = (r_wait_cnt == TO_LAST);

  // Grant only when idle; reset masks it so nothing is accepted during reset.
  assign s_gnt       = (r_state == ST_IDLE) && !rst;
  assign s_rvalid    = r_s_rvalid;
  assign s_rdata     = r_s_rdata;
  assign s_err       = r_s_err;
  assign p_req       = r_p_req;
  assign p_we        = r_p_we;
  assign p_be        = r_p_be;
  assign p_addr      = r_p_addr;
  assign p_wdata     = r_p_wdata;
  assign timeout_cnt = r_tcnt;
  assign o_dbg_state = r_state;

  // Transaction FSM: capture, request, wait for response or timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
      r_tcnt     <= 8'd0;
      r_p_req    <= 1'b0;
      r_p_we     <= 1'b0;
      r_p_be     <= 4'd0;
      r_p_addr   <= '0;
      r_p_wdata  <= 32'd0;
      r_s_rvalid <= 1'b0;
      r_s_rdata  <= 32'd0;
      r_s_err    <= 1'b0;
    end else begin
      r_s_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_req) begin
            r_p_we     <= s_we;
            r_p_be     <= s_be;
            r_p_addr   <= s_addr;
            r_p_wdata  <= s_wdata;
            r_wait_cnt <= 8'd0;
            r_p_req    <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // A timeout takes priority over a grant arriving on the same cycle.
          if (w_timeout) begin
            r_p_req    <= 1'b0;
            r_s_rvalid <= 1'b1;
            r_s_err    <= 1'b1;
            r_s_rdata  <= r_p_we ? 32'd0 : ERR_DATA;
            if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
            r_state    <= ST_RESP;
          end else if (p_gnt) begin
            r_p_req <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // A response on the timeout cycle still counts as a normal response.
          if (p_rvalid) begin
            r_s_rvalid <= 1'b1;
            r_s_err    <= 1'b0;
            r_s_rdata  <= r_p_we ? 32'd0 : p_rdata;
            r_state    <= ST_RESP;
          end else if (w_timeout) begin
            r_s_rvalid <= 1'b1;
            r_s_err    <= 1'b1;
            r_s_rdata  <= r_p_we ? 32'd0 : ERR_DATA;
            if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_timeout_bridge.sv
// Bench for obi_timeout_bridge: directed vector table, hand-written reset
// sequences, randomized transactions and timeout-counter saturation, all
// checked against a transaction-level reference model.
module tb_obi_timeout_bridge;

  localparam int          AW  = 24;
  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_req, s_gnt, s_we;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic          s_rvalid, s_err;
  logic [31:0]   s_rdata;
  logic          p_req, p_we;
  logic [3:0]    p_be;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_wdata;
  logic          p_gnt, p_rvalid;
  logic [31:0]   p_rdata;
  logic [7:0]    timeout_cnt;
  logic [1:0]    dbg_state;

  obi_timeout_bridge #(.ADDR_W(AW), .TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_gnt(s_gnt), .s_we(s_we), .s_be(s_be),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .p_req(p_req), .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .timeout_cnt(timeout_cnt), .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          g;   // cycles of p_req before the peripheral grants
    int          l;   // cycles from grant to p_rvalid
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;   // s_rvalid cycle index, counting the first p_req cycle as 0
    logic [7:0]  tcnt;
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and the peripheral's own memory
  logic [31:0] ref_mem[16];
  logic [7:0]  ref_tcnt;
  logic [31:0] per_mem[16];
  logic [3:0]  per_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // p_req is expected high from cycle 0 until the grant or the timeout cycle.
  function automatic logic [31:0] preq_mask(input int g);
    int last;
    last = (g < T - 1) ? g : T - 1;
    return (32'h1 << (last + 1)) - 32'h1;
  endfunction

  // Transaction-level reference: the response arrives g+l cycles after p_req
  // rises; anything later than cycle T-1 is a timeout answered at cycle T.
  task automatic model_txn(input txn_t t, output res_t e);
    int r;
    bit to;
    int w;
    r  = t.g + t.l;
    to = (r > T - 1);
    w  = int'(t.addr[5:2]);
    if (t.we && t.g <= T - 1)
      for (int b = 0; b < 4; b++)
        if (t.be[b]) ref_mem[w][8*b +: 8] = t.wdata[8*b +: 8];
    e.err   = to;
    e.rdata = t.we ? 32'd0 : (to ? ERR : ref_mem[w]);
    e.lat   = to ? T : r + 1;
    if (to && ref_tcnt != 8'hFF) ref_tcnt = ref_tcnt + 8'd1;
    e.tcnt  = ref_tcnt;
  endtask

  // Issue one upstream transaction and play the peripheral according to g/l.
  task automatic do_txn(input txn_t t, output res_t a, output logic [31:0] mask,
                        output bit payload_ok, output bit after_ok);
    int guard;
    logic [31:0] held_rdata;
    logic        held_err;
    a.lat = -1; a.err = 1'bx; a.rdata = 'x; a.tcnt = 'x;
    mask = 32'd0; payload_ok = 1'b1; after_ok = 1'b0;
    @(negedge clk);
    s_req = 1'b1; s_we = t.we; s_be = t.be; s_addr = t.addr; s_wdata = t.wdata;
    guard = 0;
    while (!s_gnt && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_gnt) begin
      check("grant_wait", 32'(s_gnt), 32'd1);
      s_req = 1'b0;
      return;
    end
    @(negedge clk);
    s_req = 1'b0; s_we = ~t.we; s_be = ~t.be; s_addr = ~t.addr; s_wdata = ~t.wdata;
    for (int idx = 0; idx < T + 5; idx++) begin
      if (s_rvalid) begin
        a.lat = idx; a.err = s_err; a.rdata = s_rdata; a.tcnt = timeout_cnt;
        break;
      end
      if (p_req) begin
        mask[idx] = 1'b1;
        if (p_we !== t.we || p_be !== t.be || p_addr !== t.addr || p_wdata !== t.wdata)
          payload_ok = 1'b0;
      end
      p_gnt = (idx == t.g);
      if (p_req && p_gnt) begin
        per_word = p_addr[5:2];
        if (p_we)
          for (int b = 0; b < 4; b++)
            if (p_be[b]) per_mem[per_word][8*b +: 8] = p_wdata[8*b +: 8];
      end
      p_rvalid = (idx == t.g + t.l);
      p_rdata  = p_rvalid ? per_mem[per_word] : $urandom;
      @(negedge clk);
    end
    p_gnt = 1'b0; p_rvalid = 1'b0;
    held_rdata = s_rdata; held_err = s_err;
    @(negedge clk);
    after_ok = s_gnt && !s_rvalid && (s_rdata === held_rdata) && (s_err === held_err);
  endtask

  task automatic run_and_check(input string tag, input txn_t t, input res_t e);
    res_t a;
    logic [31:0] mask;
    bit payload_ok, after_ok;
    do_txn(t, a, mask, payload_ok, after_ok);
    check({tag, ".lat"},     32'(a.lat),   32'(e.lat));
    check({tag, ".err"},     32'(a.err),   32'(e.err));
    check({tag, ".rdata"},   a.rdata,      e.rdata);
    check({tag, ".tcnt"},    32'(a.tcnt),  32'(e.tcnt));
    check({tag, ".preq"},    mask,         preq_mask(t.g));
    check({tag, ".payload"}, 32'(payload_ok), 32'd1);
    check({tag, ".after"},   32'(after_ok),   32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    txn_t t;
    res_t e;
    int   guard;
    bit   quiet;

    // Directed vectors: {we, be, addr, wdata, g, l} -> {err, rdata, lat, tcnt}
    vecs[0]  = '{'{1'b1, 4'hF, 24'h04, 32'h12345678, 0, 1},   '{1'b0, 32'h0,        2,  8'd0}};
    vecs[1]  = '{'{1'b0, 4'hF, 24'h04, 32'h0,        0, 1},   '{1'b0, 32'h12345678, 2,  8'd0}};
    vecs[2]  = '{'{1'b1, 4'h2, 24'h08, 32'hAABBCCDD, 0, 1},   '{1'b0, 32'h0,        2,  8'd0}};
    vecs[3]  = '{'{1'b0, 4'hF, 24'h08, 32'h0,        0, 1},   '{1'b0, 32'h0000CC00, 2,  8'd0}};
    vecs[4]  = '{'{1'b1, 4'hF, 24'h0C, 32'h00000055, 0, 1},   '{1'b0, 32'h0,        2,  8'd0}};
    vecs[5]  = '{'{1'b0, 4'hF, 24'h10, 32'h0,        0, 255}, '{1'b1, 32'hDEADBEEF, 16, 8'd1}};
    vecs[6]  = '{'{1'b0, 4'hF, 24'h0C, 32'h0,        0, 15},  '{1'b0, 32'h00000055, 16, 8'd1}};
    vecs[7]  = '{'{1'b0, 4'hF, 24'h04, 32'h0,        5, 1},   '{1'b0, 32'h12345678, 7,  8'd1}};
    vecs[8]  = '{'{1'b1, 4'hF, 24'h14, 32'h11112222, 2, 100}, '{1'b1, 32'h0,        16, 8'd2}};
    vecs[9]  = '{'{1'b0, 4'hF, 24'h14, 32'h0,        1, 2},   '{1'b0, 32'h11112222, 4,  8'd2}};
    vecs[10] = '{'{1'b0, 4'hF, 24'h18, 32'h0,        15, 1},  '{1'b1, 32'hDEADBEEF, 16, 8'd3}};
    vecs[11] = '{'{1'b0, 4'hF, 24'h0C, 32'h0,        14, 1},  '{1'b0, 32'h00000055, 16, 8'd3}};

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'd0;
      per_mem[i] = 32'd0;
    end
    ref_tcnt = 8'd0;
    per_word = 4'd0;

    // Reset block
    rst = 1'b1; s_req = 1'b0; s_we = 1'b0; s_be = 4'd0; s_addr = '0; s_wdata = 32'd0;
    p_gnt = 1'b0; p_rvalid = 1'b0; p_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst.s_gnt",    32'(s_gnt),       32'd0);
    check("rst.s_rvalid", 32'(s_rvalid),    32'd0);
    check("rst.s_err",    32'(s_err),       32'd0);
    check("rst.s_rdata",  s_rdata,          32'd0);
    check("rst.p_req",    32'(p_req),       32'd0);
    check("rst.p_we",     32'(p_we),        32'd0);
    check("rst.p_be",     32'(p_be),        32'd0);
    check("rst.p_addr",   32'(p_addr),      32'd0);
    check("rst.p_wdata",  p_wdata,          32'd0);
    check("rst.tcnt",     32'(timeout_cnt), 32'd0);
    check("rst.state",    32'(dbg_state),   32'd0);
    rst = 1'b0;
    #1;
    check("rst.first_gnt", 32'(s_gnt), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      model_txn(vecs[i].t, e);
      run_and_check($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);
    end

    // Reset while waiting for a response
    @(negedge clk);
    s_req = 1'b1; s_we = 1'b0; s_be = 4'hF; s_addr = 24'h0C; s_wdata = 32'd0;
    guard = 0;
    while (!s_gnt && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rstwait.gnt", 32'(s_gnt), 32'd1);
    @(negedge clk);
    s_req = 1'b0;
    p_gnt = 1'b1;
    @(negedge clk);
    p_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait.s_rvalid", 32'(s_rvalid),    32'd0);
    check("rstwait.p_req",    32'(p_req),       32'd0);
    check("rstwait.tcnt",     32'(timeout_cnt), 32'd0);
    check("rstwait.gnt_low",  32'(s_gnt),       32'd0);
    rst = 1'b0;
    #1;
    check("rstwait.gnt_after", 32'(s_gnt), 32'd1);
    ref_tcnt = 8'd0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_rvalid || p_req || !s_gnt) quiet = 1'b0;
    end
    check("rstwait.quiet", 32'(quiet), 32'd1);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.be    = 4'($urandom_range(0, 15));
      t.addr  = 24'($urandom) & 24'hFFFFFC;
      t.wdata = $urandom;
      t.g     = $urandom_range(0, T + 2);
      t.l     = $urandom_range(1, T + 2);
      model_txn(t, e);
      run_and_check($sformatf("rnd%0d", i), t, e);
    end

    // Drive the timeout counter into saturation
    for (int i = 0; i < 260; i++) begin
      t = '{1'b0, 4'hF, 24'h0, 32'h0, 0, 255};
      model_txn(t, e);
      run_and_check($sformatf("sat%0d", i), t, e);
    end
    check("sat.final", 32'(timeout_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
